// File: rtl/eth_line_driver_if.sv
// Transmitter-to-line-driver signal bundle: Manchester stream in, line pair and status out.
interface eth_line_driver_if;
    logic tx_in;
    logic tx_active;
    logic tx_p;
    logic tx_n;
    logic nlp_strobe;
    logic busy;

    modport master (
        output tx_in,
        output tx_active,
        input  tx_p,
        input  tx_n,
        input  nlp_strobe,
        input  busy
    );

    modport slave (
        input  tx_in,
        input  tx_active,
        output tx_p,
        output tx_n,
        output nlp_strobe,
        output busy
    );
endinterface

// File: rtl/eth_line_driver.sv
// 10BASE-T line output stage: drives the differential pair from the Manchester stream,
// appends the TP_IDL tail after each frame and emits Normal Link Pulses while idle.
module eth_line_driver #(
    parameter int unsigned NLP_PERIOD = 320000,
    parameter int unsigned NLP_WIDTH  = 2,
    parameter int unsigned TPIDL_LEN  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    eth_line_driver_if.slave line
);
    localparam int unsigned   TW           = $clog2(NLP_PERIOD);
    localparam logic [TW-1:0] T_ZERO       = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE        = TW'(32'd1);
    localparam logic [TW-1:0] T_NLP_LAST   = TW'(NLP_PERIOD - 32'd1);
    localparam logic [TW-1:0] T_WIDTH_LAST = TW'(NLP_WIDTH - 32'd1);
    localparam logic [TW-1:0] T_TPIDL_LAST = TW'(TPIDL_LEN - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TPIDL = 2'd2,
        ST_NLP   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_t;
    logic [TW-1:0] w_t_nxt;
    logic          w_strobe_nxt;
    logic          w_p_nxt;
    logic          w_n_nxt;
    logic          r_tx_p;
    logic          r_tx_n;
    logic          r_nlp_strobe;
    logic          r_busy;

    // Next state, timer and the line values belonging to the next state; a new frame
    // always wins over a tail or pulse in progress.
    always_comb begin
        w_state_nxt  = r_state;
        w_t_nxt      = r_t + T_ONE;
        w_strobe_nxt = 1'b0;
        w_p_nxt      = 1'b0;
        w_n_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (line.tx_active) begin
                    w_state_nxt = ST_DATA;
                    w_t_nxt     = T_ZERO;
                end else if (r_t == T_NLP_LAST) begin
                    w_state_nxt  = ST_NLP;
                    w_t_nxt      = T_ZERO;
                    w_strobe_nxt = 1'b1;
                end else begin
                    w_t_nxt = r_t + T_ONE;
                end
            end
            ST_DATA: begin
                if (line.tx_active) begin
                    w_state_nxt = ST_DATA;
                    w_t_nxt     = T_ZERO;
                end else begin
                    w_state_nxt = ST_TPIDL;
                    w_t_nxt     = T_ZERO;
                end
            end
            ST_TPIDL: begin
                if (line.tx_active) begin
                    w_state_nxt = ST_DATA;
                    w_t_nxt     = T_ZERO;
                end else if (r_t == T_TPIDL_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_t_nxt     = T_ZERO;
                end else begin
                    w_t_nxt = r_t + T_ONE;
                end
            end
            ST_NLP: begin
                if (line.tx_active) begin
                    w_state_nxt = ST_DATA;
                    w_t_nxt     = T_ZERO;
                end else if (r_t == T_WIDTH_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_t_nxt     = T_ZERO;
                end else begin
                    w_t_nxt = r_t + T_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_t_nxt     = T_ZERO;
            end
        endcase

        case (w_state_nxt)
            ST_DATA: begin
                w_p_nxt = line.tx_in;
                w_n_nxt = ~line.tx_in;
            end
            ST_TPIDL, ST_NLP: begin
                w_p_nxt = 1'b1;
                w_n_nxt = 1'b0;
            end
            default: begin
                w_p_nxt = 1'b0;
                w_n_nxt = 1'b0;
            end
        endcase
    end

    // State and timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_t     <= T_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
        end
    end

    // Registered line pair and status, one cycle behind the sampled inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_p       <= 1'b0;
            r_tx_n       <= 1'b0;
            r_nlp_strobe <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_tx_p       <= w_p_nxt;
            r_tx_n       <= w_n_nxt;
            r_nlp_strobe <= w_strobe_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign line.tx_p       = r_tx_p;
    assign line.tx_n       = r_tx_n;
    assign line.nlp_strobe = r_nlp_strobe;
    assign line.busy       = r_busy;
endmodule

// File: tb/tb_eth_line_driver.sv
// Scoreboard bench for eth_line_driver: randomized frames/gaps against an event-level
// line model (quiet-time and high-time counters), plus directed reset and priority cases.
module tb_eth_line_driver;
    localparam int NLP_PERIOD = 100;
    localparam int NLP_WIDTH  = 2;
    localparam int TPIDL_LEN  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    eth_line_driver_if line ();

    eth_line_driver #(
        .NLP_PERIOD(NLP_PERIOD),
        .NLP_WIDTH (NLP_WIDTH),
        .TPIDL_LEN (TPIDL_LEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .line (line)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic p;
        logic n;
        logic s;
        logic b;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Line model: quiet = consecutive zero-line cycles, hold = remaining high cycles.
    int   m_quiet = 1;
    int   m_hold  = 0;
    bit   m_was_active = 1'b0;
    bit   m_pulse_started = 1'b0;

    task automatic chk(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, want, $time);
        end
    endtask

    task automatic model_step(input logic act, input logic din, output exp_t e);
        e = '0;
        m_pulse_started = 1'b0;
        if (!rst_n) begin
            m_quiet      = 1;
            m_hold       = 0;
            m_was_active = 1'b0;
        end else if (act) begin
            e.p          = din;
            e.n          = ~din;
            e.b          = 1'b1;
            m_hold       = 0;
            m_quiet      = 0;
            m_was_active = 1'b1;
        end else begin
            if (m_was_active) begin
                m_hold       = TPIDL_LEN;
                m_was_active = 1'b0;
            end else if (m_hold == 0 && m_quiet == NLP_PERIOD) begin
                m_hold          = NLP_WIDTH;
                e.s             = 1'b1;
                m_pulse_started = 1'b1;
            end
            if (m_hold > 0) begin
                e.p = 1'b1;
                e.b = 1'b1;
                m_hold--;
                m_quiet = 0;
            end else begin
                m_quiet++;
            end
        end
    endtask

    task automatic step(input logic rst_v, input logic act, input logic din);
        exp_t e;
        @(negedge clk);
        rst_n          = rst_v;
        line.tx_active = act;
        line.tx_in     = din;
        model_step(act, din, e);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic rand_frame(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'($urandom & 1));
    endtask

    // Monitor: compare every post-edge output against the scoreboard and line invariants.
    initial begin
        exp_t e_m;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e_m = sb_q.pop_front();
                chk("tx_p", line.tx_p, e_m.p);
                chk("tx_n", line.tx_n, e_m.n);
                chk("nlp_strobe", line.nlp_strobe, e_m.s);
                chk("busy", line.busy, e_m.b);
            end
            chk("never_both_high", line.tx_p & line.tx_n, 1'b0);
            if (line.busy) chk("busy_differential", line.tx_n, ~line.tx_p);
        end
    end

    // Stimulus sequence.
    initial begin
        logic [63:0] pat;
        bit          found;
        int          gap;

        line.tx_active = 1'b1;
        line.tx_in     = 1'b0;
        #1 rst_n = 1'b0;

        // Reset held with an active, toggling frame; then idle through two NLPs.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'(i & 1));
        step(1'b1, 1'b0, 1'b0);
        idle(230);

        // 64 half-bit frame of 1,0,1,1,... then tail and next NLP.
        pat = 64'hBBBB_BBBB_BBBB_BBBB;
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, pat[63-i]);
        idle(120);

        // Frame arriving on the second NLP cycle.
        found = 1'b0;
        for (int i = 0; i < 3 * NLP_PERIOD && !found; i++) begin
            step(1'b1, 1'b0, 1'b0);
            found = m_pulse_started;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL nlp_wait: no NLP within %0d cycles", 3 * NLP_PERIOD);
        end
        rand_frame(10);
        idle(10);

        // Frame arriving on TP_IDL cycle 3.
        rand_frame(16);
        idle(2);
        rand_frame(12);
        idle(120);

        // Asynchronous reset in the middle of a frame.
        rand_frame(19);
        step(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_tx_p", line.tx_p, 1'b0);
        chk("async_rst_tx_n", line.tx_n, 1'b0);
        chk("async_rst_strobe", line.nlp_strobe, 1'b0);
        chk("async_rst_busy", line.busy, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'(i & 1));
        step(1'b1, 1'b0, 1'b0);
        idle(110);

        // Random bursts with random gaps, including back-to-back and tail-truncating gaps.
        for (int k = 0; k < 8; k++) begin
            gap = (($urandom & 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 130));
            idle(gap);
            rand_frame(int'($urandom_range(1, 40)));
        end
        idle(110);

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
